line_buffer_fetch: RTL and testbench

//  Scanline prefetch client on the SDRAM arbiter's line-buffer port (lb_*).
//  At the end of each scanline it burst-reads the next display line of RGB565 pixels
//  (80 x 128-bit words) into a ping-pong line buffer. Meanwhile it serves the line

---
 rtl/line_buffer_fetch_pkg.sv | 14 +
 rtl/line_buffer_fetch_if.sv | 10 +
 rtl/line_buffer_fetch_ram.sv | 23 ++
 rtl/line_buffer_fetch.sv | 81 ++++++++
 tb/tb_line_buffer_fetch.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/line_buffer_fetch_pkg.sv
// lb_pkg: display timing constants and types shared by the scanline prefetch block
package lb_pkg;
  localparam int H_TOTAL = 800;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL = 525;
  localparam int WORDS_PER_LINE = H_ACTIVE / 8;
  typedef enum logic [1:0] {IDLE, REQ, ACK} lb_state_t;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
endpackage

// File: rtl/line_buffer_fetch_if.sv
// line_buffer_fetch_if: the arbiter's line-buffer read port
interface line_buffer_fetch_if;
  logic         lb_sdram_Wait;
  logic         lb_sdram_ac;
  logic [127:0] lb_sdram_data;
  logic         lb_sdram_rd;
  logic [21:0]  lb_sdram_addr;
  modport master(input lb_sdram_Wait, lb_sdram_ac, lb_sdram_data, output lb_sdram_rd, lb_sdram_addr);
  modport slave(output lb_sdram_Wait, lb_sdram_ac, lb_sdram_data, input lb_sdram_rd, lb_sdram_addr);
endinterface

// File: rtl/line_buffer_fetch_ram.sv
// line_buffer_ram: 2-bank x 80-word ping-pong store with a registered pixel read port
module line_buffer_ram import lb_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_we,
  input  logic         i_wbank,
  input  logic [6:0]   i_waddr,
  input  logic [127:0] i_wdata,
  input  logic         i_rbank,
  input  logic [6:0]   i_raddr,
  input  logic [2:0]   i_rlane,
  input  logic         i_rvalid,
  output rgb565_t      o_pixel
);
  logic [127:0] r_mem [2][WORDS_PER_LINE];
  rgb565_t r_pixel;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_wbank][i_waddr] <= i_wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_pixel <= '0;
    else r_pixel <= i_rvalid ? rgb565_t'(r_mem[i_rbank][i_raddr][{i_rlane, 4'b0000} +: 16]) : '0;
  assign o_pixel = r_pixel;
endmodule

// File: rtl/line_buffer_fetch.sv
// line_buffer_fetch: burst-fetches the next scanline into a ping-pong buffer while
// serving the displayed line to the VGA pipeline by DrawX
module line_buffer_fetch import lb_pkg::*; #(
  parameter logic [21:0] FB_BASE   = 22'h000000,
  parameter int          TRIGGER_X = H_TOTAL - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  line_buffer_fetch_if.master bus,
  output logic                lb_Busy,
  output logic                lb_done,
  output logic [15:0]         pixel,
  output logic                lb_overrun
);
  lb_state_t r_state;
  logic r_fill_bank, r_busy, r_done, r_overrun;
  logic [6:0] r_word_idx;
  logic [9:0] r_tgt_line;
  logic [9:0] w_next_line;
  logic w_trig, w_rd, w_we, w_last, w_visible;
  rgb565_t w_pixel;
  assign w_next_line = (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
  assign w_trig = (DrawX == 10'(TRIGGER_X)) && (w_next_line < 10'(V_ACTIVE));
  assign w_rd = (r_state == REQ) && !bus.lb_sdram_Wait;
  // an ack landing on the trigger edge belongs to the aborted fetch
  assign w_we = w_rd && bus.lb_sdram_ac && !w_trig;
  assign w_last = r_word_idx == 7'(WORDS_PER_LINE - 1);
  assign w_visible = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
  assign bus.lb_sdram_rd = w_rd;
  assign bus.lb_sdram_addr = (r_state == REQ)
    ? FB_BASE + 22'(r_tgt_line) * 22'(WORDS_PER_LINE) + 22'(r_word_idx) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_fill_bank <= 1'b0;
      r_word_idx <= '0;
      r_tgt_line <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_trig) begin
      r_state <= REQ;
      r_busy <= 1'b1;
      r_fill_bank <= ~r_fill_bank;
      r_word_idx <= '0;
      r_tgt_line <= w_next_line;
      r_overrun <= r_overrun || r_busy;
      r_done <= r_done && (w_next_line != '0);
    end else begin
      case (r_state)
        REQ: if (w_rd && bus.lb_sdram_ac) r_state <= ACK;
        ACK: begin
          r_word_idx <= r_word_idx + 7'd1;
          r_state <= w_last ? IDLE : REQ;
          r_busy <= !w_last;
          r_done <= r_done || (w_last && r_tgt_line == 10'(V_ACTIVE - 1));
        end
        default: ;
      endcase
    end
  // the display bank is always the one not being filled
  line_buffer_ram u_ram (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_we),
    .i_wbank  (r_fill_bank),
    .i_waddr  (r_word_idx),
    .i_wdata  (bus.lb_sdram_data),
    .i_rbank  (~r_fill_bank),
    .i_raddr  (DrawX[9:3]),
    .i_rlane  (DrawX[2:0]),
    .i_rvalid (w_visible),
    .o_pixel  (w_pixel)
  );
  assign pixel = w_pixel;
  assign lb_Busy = r_busy;
  assign lb_done = r_done;
  assign lb_overrun = r_overrun;
endmodule

// File: tb/tb_line_buffer_fetch.sv
// tb_line_buffer_fetch: scoreboard bench; models the arbiter and checks addresses,
// handshake timing, status flags and displayed pixels
module tb_line_buffer_fetch;
  localparam logic [21:0] FB = 22'h012340;
  localparam int WPL = 80;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic lb_Busy, lb_done, lb_overrun;
  logic [15:0] pixel;
  int n_vec = 0, n_bad = 0, last_line = -1;
  logic [21:0] q_addr[$];
  logic [15:0] q_pix[$];
  line_buffer_fetch_if bus();
  line_buffer_fetch #(.FB_BASE(FB)) dut (
    .clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .bus(bus),
    .lb_Busy(lb_Busy), .lb_done(lb_done), .pixel(pixel), .lb_overrun(lb_overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] pat_pix(input int l, input int x);
    return {6'(l), 7'(x / 8), 3'(x % 8)};
  endfunction
  function automatic logic [127:0] pat_word(input int l, input int w);
    logic [127:0] d;
    for (int p = 0; p < 8; p++) d[16*p +: 16] = pat_pix(l, w * 8 + p);
    return d;
  endfunction
  task automatic run_fetch(input int y, input int dly, input int wait_at, input int stop_at,
                           input bit late_ac, input bit sweep);
    int nl, w, cnt, hold;
    bit waited, acked;
    nl = (y == 524) ? 0 : y + 1;
    w = 0; cnt = 0; hold = 0; waited = 0; acked = 0;
    q_addr.delete();
    for (int i = 0; i < WPL; i++) q_addr.push_back(FB + 22'(nl * WPL + i));
    DrawY = 10'(y); DrawX = 10'd799;
    bus.lb_sdram_ac = late_ac; bus.lb_sdram_data = '1;
    cyc();
    DrawX = '0; bus.lb_sdram_ac = 1'b0;
    chk("busy_rise", lb_Busy, 1);
    if (nl == 0) chk("done_clr", lb_done, 0);
    if (sweep) begin
      bus.lb_sdram_Wait = 1'b1;
      for (int k = 0; k < 642; k++) begin
        int xx, yy;
        xx = (k < 640) ? k : (k == 640 ? 700 : 5);
        yy = (k == 641) ? 500 : nl;
        DrawX = 10'(xx); DrawY = 10'(yy);
        q_pix.push_back((xx < 640 && yy < 480) ? pat_pix(last_line, xx) : 16'h0);
        cyc();
        chk("pixel", pixel, q_pix.pop_front());
      end
      DrawX = '0; DrawY = 10'(y);
    end
    for (int t = 0; t < 3000 && w < stop_at; t++) begin
      bus.lb_sdram_Wait = hold > 0;
      #1;
      if (acked) begin
        chk("ack_gap_rd", bus.lb_sdram_rd, 0);
        acked = 0;
      end else if (hold > 0) begin
        hold--;
        chk("wait_rd", bus.lb_sdram_rd, 0);
        chk("wait_addr", bus.lb_sdram_addr, q_addr[0]);
      end else if (bus.lb_sdram_rd) begin
        chk("addr", bus.lb_sdram_addr, q_addr[0]);
        if (w == wait_at && !waited) begin
          waited = 1; hold = 20; cnt = 0;
        end else if (cnt >= dly) begin
          bus.lb_sdram_ac = 1'b1;
          bus.lb_sdram_data = pat_word(nl, w);
          void'(q_addr.pop_front());
          w++; cnt = 0; acked = 1;
        end else cnt++;
      end
      cyc();
      bus.lb_sdram_ac = 1'b0;
    end
    chk("words", w, stop_at);
    if (stop_at == WPL) begin
      chk("busy_hold", lb_Busy, 1);
      cyc();
      chk("busy_fall", lb_Busy, 0);
      chk("done", lb_done, nl == 479);
      for (int i = 0; i < 4; i++) begin
        chk("idle_rd", bus.lb_sdram_rd, 0);
        cyc();
      end
      last_line = nl;
    end
  endtask
  initial begin
    bus.lb_sdram_Wait = 1'b0; bus.lb_sdram_ac = 1'b0; bus.lb_sdram_data = '0;
    repeat (2) cyc();
    chk("rst_busy", lb_Busy, 0);
    chk("rst_rd", bus.lb_sdram_rd, 0);
    chk("rst_addr", bus.lb_sdram_addr, 0);
    chk("rst_done", lb_done, 0);
    chk("rst_pixel", pixel, 0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("pre_rd", bus.lb_sdram_rd, 0);
    run_fetch(10, 3, -1, WPL, 0, 0);
    run_fetch(20, 1, 30, WPL, 0, 0);
    run_fetch(21, 0, -1, WPL, 0, 1);
    run_fetch(30, 1, -1, 40, 0, 0);
    chk("no_overrun", lb_overrun, 0);
    repeat (3) cyc();
    run_fetch(31, 1, -1, WPL, 1, 0);
    chk("overrun", lb_overrun, 1);
    run_fetch(478, 0, -1, WPL, 0, 0);
    for (int y = 479; y < 524; y++) begin
      DrawY = 10'(y); DrawX = 10'd799;
      cyc();
      chk("vblank_done", lb_done, 1);
      chk("vblank_busy", lb_Busy, 0);
      chk("vblank_rd", bus.lb_sdram_rd, 0);
    end
    DrawX = '0;
    run_fetch(524, 0, -1, WPL, 0, 0);
    run_fetch(100, 2, -1, 37, 0, 0);
    reset = 1'b1;
    cyc();
    chk("mid_rst_busy", lb_Busy, 0);
    chk("mid_rst_rd", bus.lb_sdram_rd, 0);
    chk("mid_rst_addr", bus.lb_sdram_addr, 0);
    chk("mid_rst_overrun", lb_overrun, 0);
    chk("mid_rst_pixel", pixel, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("post_rst_rd", bus.lb_sdram_rd, 0);
    end
    run_fetch(200, 0, -1, WPL, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
